// File: rtl/dmem_sized_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_sized_ctrl
//
// Byte-addressable data memory for the load/store path. It supports byte,
// halfword and word accesses with sign or zero extension on loads. Requests
// use a valid/ready handshake, and each accepted request gets a one-cycle
// registered response. A sequential clear engine zeroes the array after reset
// or when clr is pulsed.
//
// Optional build macro:
//   DMEM_MISALIGN_TRAP_EN  - misaligned half/word accesses fault. When the
//                            macro is undefined, the low address bits are
//                            forced to natural alignment.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   clr           one-cycle request to re-zero the array (ignored while busy)
//   busy          clear engine running
//   req_valid     request present
//   req_ready     request can be accepted this cycle
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  zero-extend loads
//   req_addr      byte address
//   req_wdata     right-aligned store data
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     extended load data, 0 for stores and errors
//   rsp_err       access fault, qualified by rsp_valid
// -----------------------------------------------------------------------------
module dmem_sized_ctrl #(
    parameter logic [31:0] ADDR_BASE   = 32'h9600_0000,
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    output logic        busy,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned AW    = $clog2(DEPTH_BYTES);
    localparam int unsigned IW    = AW - 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [31:0]     mem_q [WORDS];

    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            hit, misal, err, accept;
    logic [IW-1:0]   idx;
    logic [1:0]      lane;
    logic [31:0]     rd_word;
    logic [3:0]      be;
    logic [31:0]     wd_rep, wmask;
    logic            mem_we;
    logic [IW-1:0]   mem_widx;
    logic [31:0]     mem_wdat;

    // Pick the addressed lane(s) out of a word and extend to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  ln,
                                                input logic        uns);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] ext_s;
        b_s = word[{ln, 3'b000} +: 8];
        h_s = word[{ln[1], 4'b0000} +: 16];
        case (size)
            2'b00:   ext_s = uns ? $signed({24'd0, b_s}) : 32'(b_s);
            2'b01:   ext_s = uns ? $signed({16'd0, h_s}) : 32'(h_s);
            default: ext_s = $signed(word);
        endcase
        return ext_s;
    endfunction

    assign busy      = (state_q == ST_CLEAR);
    assign req_ready = (state_q == ST_IDLE) && !clr;
    assign accept    = req_valid && req_ready;

    assign hit = (req_addr[31:AW] == ADDR_BASE[31:AW]);
    assign idx = req_addr[AW-1:2];

    // Halves and words are forced onto their natural lane; with the trap
    // enabled a misaligned access faults before the lane matters.
    always_comb begin
        case (req_size)
            2'b00:   lane = req_addr[1:0];
            2'b01:   lane = {req_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misal = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    assign err     = !hit || (req_size == 2'b11) || misal;
    assign rd_word = mem_q[idx];

    // Store data replicated across lanes; byte enables select the target lanes.
    always_comb begin
        case (req_size)
            2'b00: begin
                be     = 4'b0001 << lane;
                wd_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << lane;
                wd_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wd_rep = req_wdata;
            end
        endcase
        wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    // Single write port shared by the clear engine and stores. A store is a
    // read-modify-write of the addressed word, so one port covers all sizes.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = idx;
        mem_wdat = (rd_word & ~wmask) | (wd_rep & wmask);
        if (state_q == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_widx = cnt_q;
            mem_wdat = '0;
        end else if (accept && req_we && !err) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdat;
        end
    end

    // Clear engine / request FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + IW'(1);
                if (cnt_q == IW'(WORDS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
                if (clr) begin
                    state_d = ST_CLEAR;
                end
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept && err;
        rsp_rdata_d = '0;
        if (accept && !req_we && !err) begin
            rsp_rdata_d = extend_load(rd_word, req_size, lane, req_unsigned);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
module tb_dmem_sized_ctrl;

    localparam bit [31:0] B     = 32'h9600_0000;
    localparam int        DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        busy;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_sized_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .busy        (busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference memory: plain byte array indexed by offset from the base.
    bit [7:0] mm [DEPTH];

    typedef struct {
        bit        we;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        exp_err;
        string     name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    endfunction

    function automatic void model(input bit we, input bit [1:0] sz, input bit uns,
                                  input bit [31:0] addr, input bit [31:0] wd,
                                  output bit [31:0] rd, output bit err);
        int      n;
        bit      mis;
        longint  a;
        longint  off;
        rd  = 32'h0;
        err = 1'b0;
        n   = 1 << sz;
        mis = (sz == 2'd1 && (addr % 2) != 0) || (sz == 2'd2 && (addr % 4) != 0);
        if (longint'(addr) < longint'(B) || longint'(addr) >= longint'(B) + DEPTH) err = 1'b1;
        if (sz == 2'd3) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (mis) err = 1'b1;
`endif
        if (err) return;
        a   = longint'(addr) - (longint'(addr) % n);
        off = a - longint'(B);
        if (we) begin
            for (int k = 0; k < n; k++) mm[int'(off) + k] = 8'(wd >> (8 * k));
        end else begin
            for (int k = 0; k < n; k++) rd = rd | (32'(mm[int'(off) + k]) << (8 * k));
            if (!uns && n < 4 && ((rd >> (8 * n - 1)) & 32'h1) != 0)
                rd = rd | (32'hFFFF_FFFF << (8 * n));
        end
    endfunction

    // Drive a request, take it on the next edge and collect its response.
    task automatic issue(input bit we, input bit [1:0] sz, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wd, input string tag,
                         output logic [31:0] rd, output logic err);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    task automatic idle_cycle(input string tag);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rsp_idle"}, 32'(rsp_valid), 32'h0);
    endtask

    // Count edges until req_ready rises; optionally pulse clr at one count.
    task automatic wait_ready(input int pulse_at, output int n);
        n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin
            clr = (n == pulse_at);
            @(posedge clk);
            #1;
            n++;
        end
        clr = 1'b0;
    endtask

    task automatic random_ops(input int count, input string tag);
        bit [31:0] a, wd, erd;
        bit        we, uns, eerr;
        bit [1:0]  sz;
        logic [31:0] rd;
        logic        err;
        for (int i = 0; i < count; i++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if ($urandom_range(0, 7) == 0) a = B + 32'($urandom_range(1024, 4095));
            else a = B + 32'($urandom_range(0, 1023));
            issue(we, sz, uns, a, wd, tag, rd, err);
            model(we, sz, uns, a, wd, erd, eerr);
            chk($sformatf("%s_%0d_rdata", tag, i), rd, erd);
            chk($sformatf("%s_%0d_err", tag, i), 32'(err), 32'(eerr));
            if ($urandom_range(0, 3) == 0) idle_cycle(tag);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        bit [31:0]   erd;
        bit          eerr;
        int          n;

        reset = 1'b1; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        model_clear();

        // Reset state and power-up clear latency.
        #3;
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_ready(-1, n);
        chk("init_clear_cycles", 32'(n), 32'd256);
        chk("init_busy_done", 32'(busy), 32'h0);

        // Directed vectors, issued back to back.
        vecs.push_back('{1'b0, 2'd2, 1'b0, B + 32'h100, 32'h0,         32'h0000_0000, 1'b0, "ld_w_zero"});
        vecs.push_back('{1'b1, 2'd2, 1'b0, B + 32'h010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "st_w"});
        vecs.push_back('{1'b0, 2'd0, 1'b0, B + 32'h013, 32'h0,         32'hFFFF_FFDE, 1'b0, "ld_b_s"});
        vecs.push_back('{1'b0, 2'd1, 1'b1, B + 32'h010, 32'h0,         32'h0000_BEEF, 1'b0, "ld_h_u"});
        vecs.push_back('{1'b0, 2'd1, 1'b0, B + 32'h010, 32'h0,         32'hFFFF_BEEF, 1'b0, "ld_h_s"});
        vecs.push_back('{1'b0, 2'd0, 1'b1, B + 32'h012, 32'h0,         32'h0000_00AD, 1'b0, "ld_b_u"});
        vecs.push_back('{1'b1, 2'd0, 1'b0, B + 32'h004, 32'h0000_0080, 32'h0000_0000, 1'b0, "st_b"});
        vecs.push_back('{1'b0, 2'd0, 1'b0, B + 32'h004, 32'h0,         32'hFFFF_FF80, 1'b0, "raw_ld_b"});
        vecs.push_back('{1'b1, 2'd2, 1'b0, B + 32'h400, 32'h0000_0055, 32'h0000_0000, 1'b1, "st_miss"});
        vecs.push_back('{1'b0, 2'd2, 1'b0, B + 32'h400, 32'h0,         32'h0000_0000, 1'b1, "ld_miss"});
        vecs.push_back('{1'b1, 2'd3, 1'b0, B,           32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "st_rsv"});
        vecs.push_back('{1'b0, 2'd2, 1'b0, B,           32'h0,         32'h0000_0000, 1'b0, "ld_nowrite"});
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back('{1'b1, 2'd2, 1'b0, B + 32'h022, 32'h1122_3344, 32'h0000_0000, 1'b1, "st_w_mis"});
        vecs.push_back('{1'b0, 2'd2, 1'b0, B + 32'h020, 32'h0,         32'h0000_0000, 1'b0, "ld_w_mis_chk"});
`else
        vecs.push_back('{1'b1, 2'd2, 1'b0, B + 32'h022, 32'h1122_3344, 32'h0000_0000, 1'b0, "st_w_mis"});
        vecs.push_back('{1'b0, 2'd2, 1'b0, B + 32'h020, 32'h0,         32'h1122_3344, 1'b0, "ld_w_mis_chk"});
`endif
        vecs.push_back('{1'b1, 2'd1, 1'b0, B + 32'h006, 32'h1234_A5C3, 32'h0000_0000, 1'b0, "st_h_hi"});
        vecs.push_back('{1'b0, 2'd2, 1'b0, B + 32'h004, 32'h0,         32'hA5C3_0080, 1'b0, "ld_w_merge"});
        vecs.push_back('{1'b0, 2'd0, 1'b0, B + 32'h007, 32'h0,         32'hFFFF_FFA5, 1'b0, "ld_b_lane3"});
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 2'd1, 1'b1, B + 32'h011, 32'h0,         32'h0000_0000, 1'b1, "ld_h_mis"});
`else
        vecs.push_back('{1'b0, 2'd1, 1'b1, B + 32'h011, 32'h0,         32'h0000_BEEF, 1'b0, "ld_h_mis"});
`endif
        vecs.push_back('{1'b0, 2'd2, 1'b0, B + 32'h3FC, 32'h0,         32'h0000_0000, 1'b0, "ld_w_last"});
        vecs.push_back('{1'b0, 2'd3, 1'b0, B + 32'h010, 32'h0,         32'h0000_0000, 1'b1, "ld_rsv"});

        foreach (vecs[i]) begin
            issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  vecs[i].name, rd, err);
            model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, erd, eerr);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
        end
        idle_cycle("pulse");

        // Randomized traffic against the reference model.
        random_ops(300, "rnd");

        // clr in IDLE: the request presented alongside is refused; a second
        // clr mid-pass must not extend the pass.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = B + 32'h10;
        clr = 1'b1;
        #1;
        chk("clr_blocks_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        clr = 1'b0; req_valid = 1'b0;
        chk("clr_no_accept", 32'(rsp_valid), 32'h0);
        chk("clr_busy", 32'(busy), 32'h1);
        wait_ready(50, n);
        chk("clr_cycles", 32'(n), 32'd256);
        model_clear();
        for (int k = 0; k < 256; k++) begin
            issue(1'b0, 2'd2, 1'b0, B + 32'(4 * k), 32'h0, "clr_scan", rd, err);
            model(1'b0, 2'd2, 1'b0, B + 32'(4 * k), 32'h0, erd, eerr);
            chk($sformatf("clr_scan_%0d", k), rd, erd);
        end
        req_valid = 1'b0;

        // Reset while a response is on the outputs drops it at once.
        issue(1'b1, 2'd2, 1'b0, B + 32'h40, 32'hCAFE_F00D, "inflight", rd, err);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("inflight_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("inflight_busy", 32'(busy), 32'h1);
        chk("inflight_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ready(-1, n);
        chk("rst2_clear_cycles", 32'(n), 32'd256);
        model_clear();
        issue(1'b0, 2'd2, 1'b0, B + 32'h40, 32'h0, "rst2_zero", rd, err);
        chk("rst2_zero_rdata", rd, 32'h0);

        // Reset in the middle of a clr pass restarts the full count.
        issue(1'b1, 2'd2, 1'b0, B + 32'h3F8, 32'h0BAD_F00D, "pre_clr", rd, err);
        req_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midclr_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ready(-1, n);
        chk("midclr_restart_cycles", 32'(n), 32'd256);
        model_clear();
        issue(1'b0, 2'd2, 1'b0, B + 32'h3F8, 32'h0, "midclr_zero", rd, err);
        chk("midclr_zero_rdata", rd, 32'h0);
        req_valid = 1'b0;

        random_ops(60, "rnd2");
        idle_cycle("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_sized_ctrl.md
# dmem_sized_ctrl

Byte-addressable, parametrised data memory for the RISC-V core's load/store path. It supports byte, halfword and word accesses with sign or zero extension. Requests use a valid/ready handshake and complete with a single-cycle registered response. The storage array is zeroed by a sequential clear engine after reset or on command. The block sits behind the execute stage's address computation and replaces the fixed 1 KiB word-only data memory.

## Interface
Parameters:
- ADDR_BASE, 32'h9600_0000: base of the decoded window. Must be aligned to DEPTH_BYTES.
- DEPTH_BYTES, 1024: window size in bytes. Must be a power of two and ≥ 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  one-cycle request to re-zero the whole array.
- busy  out  1  high while the clear engine runs.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted; valid only with rsp_valid.

## Operation
Storage:
- DEPTH_BYTES/4 words (WORDS), each with 4 byte lanes.
- Lane i holds byte address 4k+i, little-endian.

Address decode:
- hit = req_addr[31:log2(DEPTH_BYTES)] == ADDR_BASE[31:log2(DEPTH_BYTES)].
- Word index = req_addr[log2(DEPTH_BYTES)-1:2]. Lane = req_addr[1:0].

Accept rules:
- A request is accepted when req_valid && req_ready.
- req_ready = (state == IDLE) && !clr.

Store:
- Writes only the enabled lanes.
- Byte: lane addr[1:0] gets wdata[7:0].
- Half: lanes addr[1:0] and addr[1:0]+1 get wdata[15:0].
- Word: all four lanes.
- The response is rsp_valid=1, rsp_rdata=0.

Load:
- Selects the lane(s), then sign-extends (req_unsigned=0) or zero-extends (req_unsigned=1) to 32 bits. Word ignores req_unsigned.

Errors (rsp_err=1, no write, rsp_rdata=0):
- miss (!hit);
- req_size == 11;
- misalignment (see Configuration).

State machine:
- CLEAR: writes 0 to word[cnt] and increments cnt each cycle. When cnt == WORDS-1 it moves to IDLE and cnt returns to 0. req_ready=0 and busy=1 throughout.
- IDLE: serves requests. clr=1 moves to CLEAR on the next edge, and no request is accepted that cycle.
- clr asserted while already in CLEAR has no effect; the current clear continues.

## Timing
Reset values (asserted immediately, asynchronously):
- state=CLEAR, cnt=0, busy=1, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Array contents are not reset directly; they are zeroed by the CLEAR pass.

After reset deasserts:
- The first edge clears word 0.
- req_ready first goes high after WORDS edges (256 for the default).

Reset during CLEAR or IDLE restarts the clear from word 0. Any in-flight response is dropped.

Latency:
- A request accepted at edge N produces rsp_valid, rsp_rdata and rsp_err, registered, during the cycle following edge N.
- rsp_valid is a single-cycle pulse. There is no response backpressure.
- Back-to-back requests are accepted every cycle, giving a throughput of 1 per clock.

Read-after-write:
- A load accepted one cycle after a store to the same bytes returns the new data.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is an error: rsp_err=1, no write, rsp_rdata=0.
- Undefined:
  - Low address bits are forced to alignment. Half uses lane {addr[1],0}; word uses lane 0.
  - No misalignment error is raised; only a miss or the reserved size sets rsp_err.

## Test plan
- Reset then idle: req_ready=0 for exactly 256 cycles after deassert, then 1. A word load from 0x9600_0100 returns 0x0000_0000 with err=0.
- Store word 0xDEAD_BEEF at 0x9600_0010, then load byte signed at 0x9600_0013 returns 0xFFFF_FFDE. Load half unsigned at 0x9600_0010 returns 0x0000_BEEF.
- Back-to-back: store byte 0x80 at 0x9600_0004 at edge N, then load byte signed at the same address at edge N+1. The response at N+2 is 0xFFFF_FF80.
- Address 0x9600_0400 (miss) or size 11 gives rsp_err=1 and rdata 0. A subsequent word load from 0x9600_0000 shows no write occurred.
- Misaligned word store 0x1122_3344 at 0x9600_0022:
  - With DMEM_MISALIGN_TRAP_EN: err=1 and memory unchanged.
  - Without it: err=0, and a load word from 0x9600_0020 returns 0x1122_3344.
- clr pulse in IDLE: busy=1 and req_ready=0 for 256 cycles, and all prior data reads 0 afterward. Asserting reset mid-clear restarts the full 256-cycle count.
